// File: rtl/vigna_bus_arbiter.sv
// Two-master (instruction/data) round-robin arbiter onto one valid/ready memory port,
// with a watchdog that force-completes a stalled transaction and records a sticky error.
module vigna_bus_arbiter #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  output logic [31:0] d_rdata,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  input  logic [31:0] m_rdata,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  localparam int unsigned CW = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = (TIMEOUT > 32'd0) ? CW'(TIMEOUT - 32'd1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last_d;
  logic [CW-1:0] r_cnt;
  logic          r_m_valid;
  logic [31:0]   r_m_addr;
  logic [31:0]   r_m_wdata;
  logic [3:0]    r_m_wstrb;
  logic          r_bus_err;
  logic [31:0]   r_err_addr;
  logic          w_grant_i;
  logic          w_grant_d;
  logic          w_done;
  logic          w_timeout;
  logic          w_i_ready;
  logic          w_d_ready;

  // Next-state: grant in IDLE (tie goes to the side not granted last), complete on ready or watchdog.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_valid && (!d_valid || r_last_d)) begin
          w_grant_i   = 1'b1;
          w_state_nxt = S_BUSY_I;
        end else if (d_valid) begin
          w_grant_d   = 1'b1;
          w_state_nxt = S_BUSY_D;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        w_timeout = (TIMEOUT != 32'd0) && !m_ready && (r_cnt == CNT_MAX);
        if (m_ready || w_timeout) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ready is suppressed while reset is asserted so an aborted transaction never completes.
  assign w_i_ready = (r_state == S_BUSY_I) && w_done && !reset;
  assign w_d_ready = (r_state == S_BUSY_D) && w_done && !reset;

  assign i_ready  = w_i_ready;
  assign d_ready  = w_d_ready;
  assign i_rdata  = w_i_ready ? (m_ready ? m_rdata : ERR_RDATA) : 32'h0000_0000;
  assign d_rdata  = w_d_ready ? (m_ready ? m_rdata : ERR_RDATA) : 32'h0000_0000;
  assign m_valid  = r_m_valid;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign m_wstrb  = r_m_wstrb;
  assign bus_err  = r_bus_err;
  assign err_addr = r_err_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shared-port request, round-robin history, watchdog counter and sticky error capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_valid  <= 1'b0;
      r_m_addr   <= 32'h0000_0000;
      r_m_wdata  <= 32'h0000_0000;
      r_m_wstrb  <= 4'h0;
      r_last_d   <= 1'b0;
      r_cnt      <= '0;
      r_bus_err  <= 1'b0;
      r_err_addr <= 32'h0000_0000;
    end else if (w_grant_i || w_grant_d) begin
      r_m_valid <= 1'b1;
      r_m_addr  <= w_grant_d ? d_addr  : i_addr;
      r_m_wdata <= w_grant_d ? d_wdata : i_wdata;
      r_m_wstrb <= w_grant_d ? d_wstrb : i_wstrb;
      r_last_d  <= w_grant_d;
      r_cnt     <= '0;
    end else if (w_done) begin
      r_m_valid <= 1'b0;
      if (w_timeout) begin
        r_bus_err <= 1'b1;
        if (!r_bus_err) begin
          r_err_addr <= r_m_addr;
        end
      end
    end else if (r_m_valid && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Directed bench for vigna_bus_arbiter: fetch, store, tie fairness, watchdog, reset abort
// and ready/timeout coincidence, with hand-computed expected values.
module tb_vigna_bus_arbiter;

  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_ready, d_valid, d_ready, m_valid, m_ready, bus_err;
  logic [31:0] i_addr, i_rdata, i_wdata, d_addr, d_rdata, d_wdata;
  logic [31:0] m_addr, m_rdata, m_wdata, err_addr;
  logic [3:0]  i_wstrb, d_wstrb, m_wstrb;

  int n_total = 0;
  int n_pass  = 0;

  vigna_bus_arbiter #(.TIMEOUT(4), .ERR_RDATA(ERR_VAL)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_rdata(d_rdata),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_rdata(m_rdata),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .bus_err(bus_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven afterwards, checks 1ns later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
    i_addr = 32'h0; i_wdata = 32'h0; i_wstrb = 4'h0;
    d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0; m_rdata = 32'h0;
    step(); step();
    reset = 1'b0;
    #1;
    check_val("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check_val("rst_m_addr", m_addr, 32'h0);
    check_val("rst_m_wstrb", {28'd0, m_wstrb}, 32'h0);
    check_val("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check_val("rst_err_addr", err_addr, 32'h0);
    check_val("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
    check_val("rst_rdata", i_rdata | d_rdata, 32'h0);

    // Single zero-wait fetch
    i_valid = 1'b1; i_addr = 32'h0000_0100;
    #1 check_val("fetch_pre_mvalid", {31'd0, m_valid}, 32'd0);
    step();
    m_ready = 1'b1; m_rdata = 32'h00A0_0093;
    #1;
    check_val("fetch_mvalid", {31'd0, m_valid}, 32'd1);
    check_val("fetch_maddr", m_addr, 32'h0000_0100);
    check_val("fetch_iready", {31'd0, i_ready}, 32'd1);
    check_val("fetch_irdata", i_rdata, 32'h00A0_0093);
    check_val("fetch_dready", {31'd0, d_ready}, 32'd0);
    check_val("fetch_drdata", d_rdata, 32'h0);
    step();
    i_valid = 1'b0; m_ready = 1'b0;
    #1;
    check_val("fetch_idle_mvalid", {31'd0, m_valid}, 32'd0);
    check_val("fetch_idle_iready", {31'd0, i_ready}, 32'd0);
    check_val("fetch_hold_maddr", m_addr, 32'h0000_0100);

    // Store with three wait cycles; ready lands on the watchdog cycle and must win
    d_valid = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    m_rdata = 32'hCAFE_F00D;
    for (int c = 1; c <= 3; c++) begin
      step();
      #1;
      check_val($sformatf("store_mvalid_c%0d", c), {31'd0, m_valid}, 32'd1);
      check_val($sformatf("store_wstrb_c%0d", c), {28'd0, m_wstrb}, 32'hF);
      check_val($sformatf("store_dready_c%0d", c), {31'd0, d_ready}, 32'd0);
    end
    check_val("store_maddr", m_addr, 32'h0000_2000);
    check_val("store_mwdata", m_wdata, 32'h1234_5678);
    step();
    m_ready = 1'b1;
    #1;
    check_val("store_wstrb_c4", {28'd0, m_wstrb}, 32'hF);
    check_val("coinc_dready", {31'd0, d_ready}, 32'd1);
    check_val("coinc_drdata", d_rdata, 32'hCAFE_F00D);
    check_val("store_iready", {31'd0, i_ready}, 32'd0);
    step();
    d_valid = 1'b0; m_ready = 1'b0;
    #1;
    check_val("coinc_bus_err", {31'd0, bus_err}, 32'd0);
    check_val("store_done_mvalid", {31'd0, m_valid}, 32'd0);
    check_val("store_done_dready", {31'd0, d_ready}, 32'd0);

    // Tie fairness from reset with a one-wait slave: D, I, D, I
    reset = 1'b1; i_valid = 1'b1; d_valid = 1'b1;
    i_addr = 32'h0000_0040; d_addr = 32'h0000_0080; d_wstrb = 4'h0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      exp_d = (k % 2 == 0);
      #1 check_val($sformatf("tie%0d_idle", k), {31'd0, m_valid}, 32'd0);
      step();
      #1 check_val($sformatf("tie%0d_maddr", k), m_addr, exp_d ? 32'h0000_0080 : 32'h0000_0040);
      step();
      m_ready = 1'b1; m_rdata = 32'h1000_0000 + k;
      #1;
      check_val($sformatf("tie%0d_dready", k), {31'd0, d_ready}, {31'd0, exp_d});
      check_val($sformatf("tie%0d_iready", k), {31'd0, i_ready}, {31'd0, ~exp_d});
      step();
      m_ready = 1'b0;
    end

    // Watchdog: no m_ready, completion with error data on the 4th m_valid cycle
    i_valid = 1'b0; d_valid = 1'b1; d_addr = 32'h0000_3004; m_rdata = 32'h1212_1212;
    step();
    for (int c = 1; c <= 3; c++) begin
      #1 check_val($sformatf("to_dready_c%0d", c), {31'd0, d_ready}, 32'd0);
      step();
    end
    #1;
    check_val("to_dready_c4", {31'd0, d_ready}, 32'd1);
    check_val("to_drdata", d_rdata, ERR_VAL);
    check_val("to_err_before", {31'd0, bus_err}, 32'd0);
    step();
    d_valid = 1'b0;
    #1;
    check_val("to_bus_err", {31'd0, bus_err}, 32'd1);
    check_val("to_err_addr", err_addr, 32'h0000_3004);
    check_val("to_mvalid", {31'd0, m_valid}, 32'd0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    #1 check_val("late_ready_ignored", {30'd0, i_ready, d_ready}, 32'd0);

    // Second timeout keeps the first error address
    d_valid = 1'b1; d_addr = 32'h0000_5000;
    for (int c = 0; c < 4; c++) step();
    #1 check_val("to2_dready", {31'd0, d_ready}, 32'd1);
    step();
    d_valid = 1'b0;
    #1;
    check_val("to2_err_addr", err_addr, 32'h0000_3004);
    check_val("to2_bus_err", {31'd0, bus_err}, 32'd1);

    // Reset during BUSY_I, coinciding with m_ready
    i_valid = 1'b1; i_addr = 32'h0000_0700;
    step();
    reset = 1'b1; m_ready = 1'b1; m_rdata = 32'h5555_AAAA;
    #1 check_val("rstmid_no_iready", {31'd0, i_ready}, 32'd0);
    step();
    reset = 1'b0; m_ready = 1'b0; i_valid = 1'b1; d_valid = 1'b1;
    i_addr = 32'h0000_0040; d_addr = 32'h0000_0080;
    #1;
    check_val("rstmid_mvalid", {31'd0, m_valid}, 32'd0);
    check_val("rstmid_iready", {31'd0, i_ready}, 32'd0);
    check_val("rstmid_bus_err", {31'd0, bus_err}, 32'd0);
    check_val("rstmid_err_addr", err_addr, 32'h0);
    step();
    #1;
    check_val("rstmid_tie_mvalid", {31'd0, m_valid}, 32'd1);
    check_val("rstmid_tie_grant_d", m_addr, 32'h0000_0080);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
